// File: rtl/lab_pkg.sv
// Shared types, display code constants and code helpers for the seven-segment controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lab_pkg;

  // Command opcodes carried on req_op.
  typedef enum logic [1:0] {
    WR_DIGIT  = 2'd0,
    WR_HEX    = 2'd1,
    CLEAR     = 2'd2,
    SET_BLINK = 2'd3
  } sevseg_op_t;

  // Controller FSM: single-cycle commands complete in IDLE, multi-digit writes run in SWEEP.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sevseg_state_t;

  // Codes 0..15 are hex glyphs, 16 is blank, 17 is a single line; anything above is invalid.
  localparam logic [4:0] SEVSEG_MAX_CODE    = 5'd17;
  localparam logic [4:0] SEVSEG_BLANK_INDEX = 5'd16;
  localparam logic [4:0] SEVSEG_LINE_INDEX  = 5'd17;

  // Out-of-range codes are shown as blank rather than decoding to garbage.
  function automatic logic [4:0] sevseg_sat_code(input logic [4:0] code);
    return (code > SEVSEG_MAX_CODE) ? SEVSEG_BLANK_INDEX : code;
  endfunction

  // Code for digit k of a hex value with leading-zero blanking; digit 0 is never blanked.
  function automatic logic [4:0] sevseg_hex_code(input logic [15:0] val, input int k);
    logic [15:0] upper;
    upper = val >> (4 * k);
    if (k != 0 && upper == 16'd0) begin
      return SEVSEG_BLANK_INDEX;
    end
    return {1'b0, upper[3:0]};
  endfunction

endpackage

// File: rtl/sevseg_rr_arb.sv
// Two-way round-robin arbiter; the last-grant pointer moves only when a grant is issued.
// Latency: grant is combinational from valid; pointer updates on the accepting edge.
// Backpressure: en_i low withholds every grant, so requesters simply hold their valid.
module sevseg_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] req_vld_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  // Grant the lone requester, or on a tie the one that was not served last.
  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (en_i) begin
      unique case (req_vld_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
    if (gnt_o[1]) begin
      last_d = 1'b1;
    end else if (gnt_o[0]) begin
      last_d = 1'b0;
    end
  end

  // Last-grant pointer resets to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sevseg_ctrl.sv
// Two-requester command front end holding per-digit display codes; optional blink via SEVSEG_BLINK_EN.
// Latency: single-digit/blink writes land the cycle after accept; hex and clear sweep one digit per cycle.
// Backpressure: req_ready drops for the whole sweep; held commands are taken in the first idle cycle.
module sevseg_ctrl
  import lab_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0][1:0]            req_op,
  input  logic [1:0][2:0]            req_idx,
  input  logic [1:0][15:0]           req_data,
  output logic [NUM_DIGITS-1:0][4:0] digit_code,
  output logic                       busy
);

  // The 3-bit index covers at most 8 digits, and a hex sweep needs at least 4.
  if (NUM_DIGITS < 4 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("sevseg_ctrl: NUM_DIGITS must be in 4..8");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink_div
    $error("sevseg_ctrl: BLINK_DIV must be at least 1");
  end

  localparam int CNT_W = $clog2(NUM_DIGITS);

  sevseg_state_t             state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      clr_q, clr_d;
  logic [15:0]               hex_q, hex_d;
  logic [NUM_DIGITS-1:0][4:0] digit_q, digit_d;

  logic [1:0]       gnt;
  logic             acc;
  logic             sel;
  sevseg_op_t       cmd_op;
  logic [2:0]       cmd_idx;
  logic [15:0]      cmd_data;
  logic [CNT_W-1:0] sweep_last;

`ifdef SEVSEG_BLINK_EN
  localparam int BCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BCNT_W-1:0]     bcnt_q;
  logic                  phase_q;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
`endif

  sevseg_rr_arb u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      ((state_q == ST_IDLE) && rst_n),
    .req_vld_i (req_valid),
    .gnt_o     (gnt)
  );

  // Grant is one-hot, so the selected requester is simply whether requester 1 won.
  assign req_ready  = gnt;
  assign acc        = |gnt;
  assign sel        = gnt[1];
  assign cmd_op     = sevseg_op_t'(req_op[sel]);
  assign cmd_idx    = req_idx[sel];
  assign cmd_data   = req_data[sel];
  assign busy       = (state_q == ST_SWEEP);
  assign sweep_last = clr_q ? CNT_W'(NUM_DIGITS - 1) : CNT_W'(3);

  // Command decode in IDLE and one digit write per cycle while sweeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_d   = clr_q;
    hex_d   = hex_q;
    digit_d = digit_q;
`ifdef SEVSEG_BLINK_EN
    mask_d  = mask_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (acc) begin
          unique case (cmd_op)
            WR_DIGIT: begin
              // Indices past the last digit match no k and are silently dropped.
              for (int k = 0; k < NUM_DIGITS; k++) begin
                if (cmd_idx == 3'(k)) begin
                  digit_d[k] = sevseg_sat_code(cmd_data[4:0]);
                end
              end
            end
            WR_HEX: begin
              hex_d   = cmd_data;
              clr_d   = 1'b0;
              cnt_d   = '0;
              state_d = ST_SWEEP;
            end
            CLEAR: begin
              clr_d   = 1'b1;
              cnt_d   = '0;
              state_d = ST_SWEEP;
`ifdef SEVSEG_BLINK_EN
              mask_d  = '0;
`endif
            end
            SET_BLINK: begin
`ifdef SEVSEG_BLINK_EN
              mask_d = cmd_data[NUM_DIGITS-1:0];
`endif
            end
            default: begin
            end
          endcase
        end
      end
      ST_SWEEP: begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            digit_d[k] = clr_q ? SEVSEG_BLANK_INDEX : sevseg_hex_code(hex_q, k);
          end
        end
        if (cnt_q == sweep_last) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state and stored digit codes; reset blanks every digit and aborts any sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      clr_q   <= 1'b0;
      hex_q   <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        digit_q[k] <= SEVSEG_BLANK_INDEX;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      hex_q   <= hex_d;
      digit_q <= digit_d;
    end
  end

`ifdef SEVSEG_BLINK_EN
  // Free-running blink timebase and the per-digit blink mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      mask_q  <= '0;
    end else begin
      mask_q <= mask_d;
      if (bcnt_q == BCNT_W'(BLINK_DIV - 1)) begin
        bcnt_q  <= '0;
        phase_q <= ~phase_q;
      end else begin
        bcnt_q <= bcnt_q + 1'b1;
      end
    end
  end

  // Blinked digits show blank in phase 1 without disturbing the stored code.
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      digit_code[k] = (phase_q && mask_q[k]) ? SEVSEG_BLANK_INDEX : digit_q[k];
    end
  end
`else
  assign digit_code = digit_q;
`endif

endmodule

// File: tb/tb_sevseg_ctrl.sv
// Randomised bench for sevseg_ctrl with a queue-based reference model and a negedge monitor.
// Latency: expectations are pushed when a cycle's stimulus is driven and popped at that cycle's negedge.
// Backpressure: requesters hold commands until the model predicts a grant, or drop them at random.
module tb_sevseg_ctrl;
  import lab_pkg::*;

  localparam int N   = 6;
  localparam int DIV = 4;
`ifdef SEVSEG_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0][1:0]     req_op;
  logic [1:0][2:0]     req_idx;
  logic [1:0][15:0]    req_data;
  logic [N-1:0][4:0]   digit_code;
  logic                busy;

  always #5 clk = ~clk;

  sevseg_ctrl #(
    .NUM_DIGITS (N),
    .BLINK_DIV  (DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_idx    (req_idx),
    .req_data   (req_data),
    .digit_code (digit_code),
    .busy       (busy)
  );

  typedef struct packed {
    logic [1:0]        rdy;
    logic              busy;
    logic [N-1:0][4:0] dig;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: stored digits, blink mask, pointer, cycles since reset, pending sweep writes.
  int m_dig[N];
  int m_mask;
  int m_last;
  int m_cyc;
  int pend_k[$];
  int pend_c[$];

  // Commands currently held by each requester.
  logic [1:0] h_v;
  int         h_op[2];
  int         h_idx[2];
  int         h_dat[2];

  function void m_reset();
    for (int k = 0; k < N; k++) m_dig[k] = 16;
    m_mask = 0;
    m_last = 1;
    m_cyc  = 0;
    pend_k.delete();
    pend_c.delete();
  endfunction

  function logic [1:0] m_grant(logic [1:0] v);
    if (pend_k.size() != 0) return 2'b00;
    if (v == 2'b11) return (m_last == 1) ? 2'b01 : 2'b10;
    return v;
  endfunction

  function exp_t m_expect(logic [1:0] g);
    exp_t e;
    bit   phase;
    phase  = BLINK_EN && (((m_cyc / DIV) % 2) == 1);
    e.rdy  = g;
    e.busy = (pend_k.size() != 0);
    for (int k = 0; k < N; k++) begin
      if (phase && (((m_mask >> k) & 1) == 1)) e.dig[k] = 5'd16;
      else e.dig[k] = 5'(m_dig[k]);
    end
    return e;
  endfunction

  function void m_accept(int op, int idx, int dat);
    int code;
    case (op)
      0: begin
        if (idx < N) begin
          code = dat & 31;
          m_dig[idx] = (code > 17) ? 16 : code;
        end
      end
      1: begin
        for (int k = 0; k < 4; k++) begin
          code = (dat >> (4 * k)) & 15;
          if (k > 0 && (dat >> (4 * k)) == 0) code = 16;
          pend_k.push_back(k);
          pend_c.push_back(code);
        end
      end
      2: begin
        m_mask = 0;
        for (int k = 0; k < N; k++) begin
          pend_k.push_back(k);
          pend_c.push_back(16);
        end
      end
      default: begin
        if (BLINK_EN) m_mask = dat & ((1 << N) - 1);
      end
    endcase
  endfunction

  function void m_edge(logic [1:0] g);
    int r;
    if (pend_k.size() != 0) begin
      m_dig[pend_k.pop_front()] = pend_c.pop_front();
    end else if (g != 2'b00) begin
      r      = g[1] ? 1 : 0;
      m_last = r;
      m_accept(h_op[r], h_idx[r], h_dat[r]);
    end
    m_cyc++;
  endfunction

  task automatic issue(input int r, input int op, input int idx, input int dat);
    h_v[r]   = 1'b1;
    h_op[r]  = op;
    h_idx[r] = idx;
    h_dat[r] = dat;
  endtask

  // One clock cycle: drive held commands, queue the expected response, advance the model.
  task automatic step();
    logic [1:0] g;
    req_valid = h_v;
    for (int i = 0; i < 2; i++) begin
      req_op[i]   = 2'(h_op[i]);
      req_idx[i]  = 3'(h_idx[i]);
      req_data[i] = 16'(h_dat[i]);
    end
    g = m_grant(h_v);
    exp_q.push_back(m_expect(g));
    @(posedge clk);
    m_edge(g);
    for (int i = 0; i < 2; i++) if (g[i]) h_v[i] = 1'b0;
    #1;
  endtask

  // One cycle with reset asserted mid-cycle, released just after the next edge.
  task automatic reset_step();
    rst_n     = 1'b0;
    h_v       = 2'b00;
    req_valid = 2'b00;
    m_reset();
    exp_q.push_back(m_expect(2'b00));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: one expectation per cycle, compared away from the active edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (req_ready !== e.rdy) begin
        n_fail++;
        $display("FAIL req_ready t=%0t got %b exp %b", $time, req_ready, e.rdy);
      end
      n_tests++;
      if (busy !== e.busy) begin
        n_fail++;
        $display("FAIL busy t=%0t got %b exp %b", $time, busy, e.busy);
      end
      n_tests++;
      if (digit_code !== e.dig) begin
        n_fail++;
        $display("FAIL digit_code t=%0t got %h exp %h", $time, digit_code, e.dig);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_op    = '0;
    req_idx   = '0;
    req_data  = '0;
    h_v       = 2'b00;
    for (int i = 0; i < 2; i++) begin
      h_op[i] = 0; h_idx[i] = 0; h_dat[i] = 0;
    end
    m_reset();
    @(posedge clk);
    #1;

    // Reset state with no requests.
    reset_step();
    step();
    step();

    // Both requesters contend every cycle: grants alternate starting with requester 0.
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!h_v[i]) issue(i, 0, 3 * i + (c % 3), c + 2 * i);
      end
      step();
    end
    h_v = 2'b00;
    step();

    // Line code is kept, out-of-range code becomes blank.
    issue(0, 0, 2, 17);
    step();
    issue(0, 0, 2, 25);
    step();
    step();

    // Hex write with leading-zero blanking; requester 1 waits through the sweep.
    issue(0, 0, 4, 9);
    step();
    issue(0, 0, 5, 11);
    step();
    issue(0, 1, 0, 16'h00A3);
    step();
    issue(1, 0, 5, 2);
    for (int c = 0; c < 6; c++) step();

    // Clear aborted by reset at sweep cycle 3.
    issue(0, 2, 0, 0);
    step();
    step();
    step();
    step();
    reset_step();
    step();

`ifdef SEVSEG_BLINK_EN
    // Blink digit 0 showing 7.
    issue(0, 0, 0, 7);
    step();
    issue(0, 3, 0, 1);
    step();
    for (int c = 0; c < 16; c++) step();
`endif

    // Randomised traffic with random drops and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) reset_step();
      for (int i = 0; i < 2; i++) begin
        if (!h_v[i] && $urandom_range(0, 2) == 0) begin
          int op;
          int dat;
          op  = $urandom_range(0, 3);
          dat = $urandom_range(0, 65535);
          if (op == 0 && $urandom_range(0, 1) == 0) dat = $urandom_range(0, 31);
          if (op == 1) dat = dat >> (4 * $urandom_range(0, 3));
          issue(i, op, $urandom_range(0, 7), dat);
        end else if (h_v[i] && $urandom_range(0, 15) == 0) begin
          h_v[i] = 1'b0;
        end
      end
      step();
    end

    h_v = 2'b00;
    for (int c = 0; c < 8; c++) step();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sevseg_ctrl.md
SEVSEG_CTRL -- requirements
Module: sevseg_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 6: number of display digits driven.
REQ-002 Parameter BLINK_DIV, default 25_000_000: blink half-period in clk cycles.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  2  per-requester command valid.
REQ-006 req_ready  output  2  per-requester command accepted this cycle.
REQ-007 req_op  input  2x2  per-requester opcode (sevseg_op_t).
REQ-008 req_idx  input  2x3  per-requester digit index.
REQ-009 req_data  input  2x16  per-requester payload.
REQ-010 digit_code  output  NUM_DIGITS x 5  display code per digit, fed to one sevseg_display per digit.
REQ-011 busy  output  1  high while a multi-cycle sweep is in progress.

Function
REQ-012 States IDLE and SWEEP only; commands are accepted only in IDLE.
REQ-013 In IDLE: req_ready[i] combinationally high for exactly the granted requester i with req_valid[i] high; accept = valid & ready.
REQ-014 Arbitration: one valid -> grant it; both valid -> grant the requester not granted last (round-robin); last_grant updates on accept only.
REQ-015 Requester holds valid and payload stable until accepted; deasserting valid before accept is legal, and the command is then dropped.
REQ-016 WR_DIGIT: idx < NUM_DIGITS -> digit idx takes data[4:0] the cycle after accept; codes > 17 are stored as 16 (blank); idx >= NUM_DIGITS -> accepted, no effect; state stays IDLE.
REQ-017 WR_HEX: latch data, go to SWEEP; write digit k (k = 0..3) with nibble k, one digit per cycle, on the 4 cycles after accept; then return to IDLE.
REQ-018 WR_HEX leading-zero blanking: digit k >= 1 stored as 16 when nibbles k..3 are all zero; digit 0 always shows its nibble; digits 4..NUM_DIGITS-1 untouched.
REQ-019 CLEAR: go to SWEEP; write 16 to digits 0..NUM_DIGITS-1, one per cycle (NUM_DIGITS cycles); clear blink mask on entry.
REQ-020 SET_BLINK: blink_mask <= data[NUM_DIGITS-1:0] the cycle after accept; single cycle, stays IDLE.
REQ-021 busy = (state == SWEEP); req_ready is 0 in SWEEP; a command held valid during SWEEP is accepted in the first IDLE cycle.
REQ-022 Back-to-back single-cycle commands are accepted on consecutive cycles.

Reset
REQ-023 rst_n low: state IDLE, every digit_code = 16, busy 0, req_ready 0, last_grant = 1 (requester 0 wins the first tie), blink_mask 0, blink counter and phase 0.
REQ-024 Reset asserted mid-SWEEP aborts the sweep immediately, and all state takes its reset values.

Configuration
REQ-025 Macro SEVSEG_BLINK_EN defined: counter 0..BLINK_DIV-1 toggles phase at wrap; in phase 1, digits with a mask bit set output 16, and the stored code is preserved.
REQ-026 SEVSEG_BLINK_EN undefined: no counter or mask; digit_code equals the stored code; SET_BLINK is accepted with no effect.

Structure
REQ-027 lab_pkg holds: enum sevseg_op_t {WR_DIGIT=0, WR_HEX=1, CLEAR=2, SET_BLINK=3}; SEVSEG_MAX_CODE=17; the existing SEVSEG_BLANK_INDEX (16) and SEVSEG_LINE_INDEX (17).
REQ-028 Sub-module sevseg_rr_arb: 2-way round-robin arbiter (valid in, grant out, update on accept); the segment decode stays outside this block.

Verification
REQ-029 Reset release with no requests -> all digit_code = 16, busy 0, req_ready = 00.
REQ-030 Requester 0 WR_DIGIT idx=2 data=5'd17 -> digit 2 = 17 next cycle; then data=5'd25 -> digit 2 = 16.
REQ-031 Both requesters valid WR_DIGIT each cycle -> grants alternate 0,1,0,1; requester 0 is granted first after reset.
REQ-032 WR_HEX data=16'h00A3 -> busy for 4 cycles; digits 0..3 = 3,10,16,16; digits 4,5 unchanged; requester 1 held valid is accepted on the first IDLE cycle.
REQ-033 CLEAR issued, with rst_n pulsed low at sweep cycle 3 -> all digits 16, state IDLE, busy 0 immediately.
REQ-034 SEVSEG_BLINK_EN defined, BLINK_DIV=4, SET_BLINK data=6'b000001, digit 0 = 7 -> digit_code[0] alternates 7 and 16 every 4 cycles; other digits steady.
